// File: rtl/tcdm_reader_pkg.sv
// Shared types and constants for the TCDM strided reader.
// Optional feature macro: TCDM_READER_PERF_EN (adds stall_cnt_o).
package tcdm_reader_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2
   } state_e;

   localparam logic [3:0] AMO_NONE = 4'h0;

endpackage

// File: rtl/tcdm_reader_fifo.sv
// Response buffer for the TCDM reader; count_o feeds the credit check.
// Push and pop may coincide, including when full or empty.
module tcdm_reader_fifo #(
   parameter int unsigned Width = 64,
   parameter int unsigned Depth = 4,
   localparam int unsigned PtrW = $clog2(Depth),
   localparam int unsigned CntW = PtrW + 1
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             push_i,
   input  logic [Width-1:0] data_i,
   input  logic             pop_i,
   output logic [Width-1:0] data_o,
   output logic             empty_o,
   output logic [CntW-1:0]  count_o
);

   logic [Width-1:0] mem_q [Depth];
   logic [PtrW-1:0]  wr_q, wr_d;
   logic [PtrW-1:0]  rd_q, rd_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic             push_ok;
   logic             pop_ok;

   always_comb begin
      pop_ok  = pop_i && (cnt_q != '0);
      push_ok = push_i && ((cnt_q != CntW'(Depth)) || pop_ok);
      wr_d    = wr_q;
      rd_d    = rd_q;
      cnt_d   = cnt_q;
      if (push_ok) begin
         wr_d  = wr_q + PtrW'(1);
         cnt_d = cnt_d + CntW'(1);
      end
      if (pop_ok) begin
         rd_d  = rd_q + PtrW'(1);
         cnt_d = cnt_d - CntW'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end

   // Storage needs no reset; the count gates every read.
   always_ff @(posedge clk_i) begin
      if (push_ok) mem_q[wr_q] <= data_i;
   end

   assign data_o  = mem_q[rd_q];
   assign empty_o = (cnt_q == '0);
   assign count_o = cnt_q;

endmodule

// File: rtl/tcdm_reader.sv
// Strided TCDM reader: issues count reads at base + k*stride, streams data out.
// Optional feature macro: TCDM_READER_PERF_EN adds a saturating stall counter.
module tcdm_reader
   import tcdm_reader_pkg::*;
#(
   parameter int unsigned NarrowDataWidth = 64,
   parameter int unsigned TCDMAddrWidth   = 17,
   parameter int unsigned FifoDepth       = 4,
   parameter int unsigned CoreId          = 0
) (
   input  logic                         clk_i,
   input  logic                         rst_ni,
   input  logic                         start_i,
   input  logic [TCDMAddrWidth-1:0]     cfg_base_i,
   input  logic [TCDMAddrWidth-1:0]     cfg_stride_i,
   input  logic [15:0]                  cfg_count_i,
   output logic                         busy_o,
   output logic                         done_o,
   output logic                         tcdm_req_write_o,
   output logic [TCDMAddrWidth-1:0]     tcdm_req_addr_o,
   output logic [3:0]                   tcdm_req_amo_o,
   output logic [NarrowDataWidth-1:0]   tcdm_req_data_o,
   output logic [4:0]                   tcdm_req_user_core_id_o,
   output logic                         tcdm_req_user_is_core_o,
   output logic [NarrowDataWidth/8-1:0] tcdm_req_strb_o,
   output logic                         tcdm_req_q_valid_o,
   input  logic                         tcdm_rsp_q_ready_i,
   input  logic                         tcdm_rsp_p_valid_i,
   input  logic [NarrowDataWidth-1:0]   tcdm_rsp_data_i,
   output logic [NarrowDataWidth-1:0]   data_o,
   output logic                         valid_o,
`ifdef TCDM_READER_PERF_EN
   output logic [31:0]                  stall_cnt_o,
`endif
   input  logic                         ready_i
);

   localparam int unsigned CntW = $clog2(FifoDepth) + 1;

   state_e                     state_q, state_d;
   logic [TCDMAddrWidth-1:0]   addr_q, addr_d;
   logic [TCDMAddrWidth-1:0]   stride_q, stride_d;
   logic [15:0]                left_q, left_d;
   logic [CntW-1:0]            out_q, out_d;
   logic                       done_q, done_d;

   logic [CntW-1:0]            fifo_cnt;
   logic                       fifo_empty;
   logic [CntW:0]              credit_sum;
   logic                       q_valid;
   logic                       req_hs;
   logic                       rsp_push;
   logic                       pop;

   // Every issued read must have a guaranteed FIFO slot: no rsp backpressure.
   assign credit_sum = {1'b0, out_q} + {1'b0, fifo_cnt};
   assign rsp_push   = tcdm_rsp_p_valid_i && (state_q != IDLE)
                       && (out_q != '0);
   assign pop        = !fifo_empty && ready_i;

   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      stride_d = stride_q;
      left_d   = left_q;
      done_d   = 1'b0;
      q_valid  = 1'b0;
      req_hs   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start_i) begin
               addr_d   = cfg_base_i;
               stride_d = cfg_stride_i;
               left_d   = cfg_count_i;
               if (cfg_count_i == 16'd0) done_d  = 1'b1;
               else                      state_d = ISSUE;
            end
         end
         ISSUE: begin
            q_valid = (credit_sum < (CntW+1)'(FifoDepth));
            req_hs  = q_valid && tcdm_rsp_q_ready_i;
            if (req_hs) begin
               addr_d = addr_q + stride_q;
               left_d = left_q - 16'd1;
               if (left_q == 16'd1) state_d = DRAIN;
            end
         end
         DRAIN: begin
            if ((out_q == '0) && fifo_empty) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      out_d = out_q;
      if (req_hs)   out_d = out_d + CntW'(1);
      if (rsp_push) out_d = out_d - CntW'(1);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= IDLE;
         addr_q   <= '0;
         stride_q <= '0;
         left_q   <= '0;
         out_q    <= '0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         stride_q <= stride_d;
         left_q   <= left_d;
         out_q    <= out_d;
         done_q   <= done_d;
      end
   end

   tcdm_reader_fifo #(
      .Width (NarrowDataWidth),
      .Depth (FifoDepth)
   ) i_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .push_i  (rsp_push),
      .data_i  (tcdm_rsp_data_i),
      .pop_i   (pop),
      .data_o  (data_o),
      .empty_o (fifo_empty),
      .count_o (fifo_cnt)
   );

`ifdef TCDM_READER_PERF_EN
   logic [31:0] stall_cnt_q, stall_cnt_d;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if ((state_q == IDLE) && start_i) begin
         stall_cnt_d = '0;
      end else if (q_valid && !tcdm_rsp_q_ready_i
                   && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) stall_cnt_q <= '0;
      else         stall_cnt_q <= stall_cnt_d;
   end

   assign stall_cnt_o = stall_cnt_q;
`endif

   assign tcdm_req_write_o        = 1'b0;
   assign tcdm_req_amo_o          = AMO_NONE;
   assign tcdm_req_data_o         = '0;
   assign tcdm_req_strb_o         = '1;
   assign tcdm_req_user_is_core_o = 1'b0;
   assign tcdm_req_user_core_id_o = 5'(CoreId);
   assign tcdm_req_addr_o         = addr_q;
   assign tcdm_req_q_valid_o      = q_valid;
   assign valid_o                 = !fifo_empty;
   assign busy_o                  = (state_q != IDLE);
   assign done_o                  = done_q;

endmodule

// File: doc/tcdm_reader.md
TCDM_READER -- requirements
Module: tcdm_reader

Interface
REQ-001 SHALL have param NarrowDataWidth, default 64, data width of the TCDM port and output stream.
REQ-002 SHALL have param TCDMAddrWidth, default 17, byte address width of the TCDM port.
REQ-003 SHALL have param FifoDepth, default 4, response buffer entries; must be ≥2 and a power of 2.
REQ-004 SHALL have param CoreId, default 0, 5-bit value driven on tcdm_req_user_core_id_o.
REQ-005 SHALL have port clk_i  in  1  sole clock.
REQ-006 SHALL have port rst_ni  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have port start_i  in  1  pulse that launches a transfer.
REQ-008 SHALL have port cfg_base_i  in  TCDMAddrWidth  first byte address.
REQ-009 SHALL have port cfg_stride_i  in  TCDMAddrWidth  byte increment per word.
REQ-010 SHALL have port cfg_count_i  in  16  number of words to read.
REQ-011 SHALL have port busy_o  out  1  transfer in progress.
REQ-012 SHALL have port done_o  out  1  one-cycle completion pulse.
REQ-013 SHALL have ports tcdm_req_write_o 1, tcdm_req_addr_o TCDMAddrWidth, tcdm_req_amo_o 4, tcdm_req_data_o NarrowDataWidth, tcdm_req_user_core_id_o 5, tcdm_req_user_is_core_o 1, tcdm_req_strb_o NarrowDataWidth/8, tcdm_req_q_valid_o 1, all out, forming the TCDM request channel.
REQ-014 SHALL have ports tcdm_rsp_q_ready_i 1, tcdm_rsp_p_valid_i 1, tcdm_rsp_data_i NarrowDataWidth, all in, forming the TCDM response channel.
REQ-015 SHALL have ports data_o out NarrowDataWidth, valid_o out 1, ready_i in 1, forming the output stream.

Function
REQ-016 SHALL drive write=0, amo=4'h0, data=0, strb=all ones, is_core=0 and core_id=CoreId constantly.
REQ-017 SHALL use FSM states IDLE, ISSUE and DRAIN.
REQ-018 SHALL, in IDLE on start_i, latch cfg_* and go to ISSUE; if cfg_count_i==0 it SHALL instead return to IDLE and pulse done_o on the next cycle with no requests issued.
REQ-019 SHALL ignore start_i when not in IDLE.
REQ-020 SHALL issue request k (k=0..count-1) at address base + k*stride, taken modulo 2^TCDMAddrWidth so it wraps silently.
REQ-021 SHALL hold q_valid and addr stable until q_valid && q_ready, then advance in the same cycle; back-to-back issue every cycle SHALL be possible.
REQ-022 SHALL assert q_valid only when outstanding + fifo_occupancy < FifoDepth, because the response channel has no backpressure.
REQ-023 SHALL count outstanding as +1 on request handshake and -1 on p_valid, both in the same cycle allowed.
REQ-024 SHALL push tcdm_rsp_data_i into the FIFO on p_valid; responses return in request order.
REQ-025 SHALL present the FIFO head on data_o/valid_o; pop on valid_o && ready_i; push and pop in the same cycle allowed, including when full or empty.
REQ-026 SHALL go from ISSUE to DRAIN after the last request handshake.
REQ-027 SHALL, in DRAIN, when outstanding==0 and FIFO empty, go to IDLE and pulse done_o for exactly one cycle.
REQ-028 SHALL assert busy_o in ISSUE and DRAIN.
REQ-029 SHALL have no combinational path from ready_i to tcdm_req_q_valid_o.

Reset
REQ-030 SHALL, on rst_ni low, asynchronously enter IDLE, clear outstanding and FIFO pointers, and drive q_valid_o=0, valid_o=0, busy_o=0, done_o=0, addr_o=0.
REQ-031 SHALL, on reset mid-transfer, abandon the transfer; responses arriving before the next start are not required and are discarded while IDLE.

Configuration
REQ-032 SHALL, when macro TCDM_READER_PERF_EN is defined, add output stall_cnt_o (32 bits), counting cycles with q_valid_o && !q_ready_i, cleared on start, saturating at 2^32-1.
REQ-033 SHALL, without TCDM_READER_PERF_EN, have no stall_cnt_o port and no counter logic.

Structure
REQ-034 SHALL place the FSM state enum and the AMO-none constant (4'h0) in shared package tcdm_reader_pkg.
REQ-035 SHALL implement the response buffer as sub-module tcdm_reader_fifo (depth FifoDepth, with count output used for credits).

Verification
REQ-036 Bench SHALL cover: base=0x100, stride=8, count=4, q_ready=1, ready_i=1 -> addrs 0x100,0x108,0x110,0x118 on consecutive cycles; 4 words out in order; done_o pulses once.
REQ-037 Bench SHALL cover: count=0 -> no q_valid, done_o high exactly one cycle after start.
REQ-038 Bench SHALL cover: FifoDepth=4, ready_i=0, count=8 -> exactly 4 requests issued, q_valid low thereafter; raising ready_i -> remaining 4 issued, all 8 words delivered.
REQ-039 Bench SHALL cover: q_ready toggling 0/1 -> addr stable while stalled, no skipped or duplicated addresses; with PERF_EN, stall_cnt_o equals the stalled cycles.
REQ-040 Bench SHALL cover: base=0x1FFF8, stride=8, count=2, TCDMAddrWidth=17 -> addrs 0x1FFF8, 0x00000.
REQ-041 Bench SHALL cover: rst_ni low during ISSUE -> all outputs at reset values immediately; a new start afterwards completes normally.
